// File: rtl/riscv_mc_ctrl.sv
// riscv_mc_ctrl -- multicycle control unit for a small RV32I subset
// (R-type ALU, I-type ALU, LW, SW).
//
// Each instruction walks FETCH -> DECODE -> EXEC -> [MEM] -> [WB]. Any
// opcode outside the subset, and a data access that never completes, park
// the FSM in TRAP. Only rst leaves TRAP.
//
// Ports
//   clock     in   1      sole clock, rising edge
//   rst       in   1      synchronous active-high reset
//   instruct  in   32     instruction word for the current PC
//   dmem_ack  in   1      data memory finished the current access
//   ir_we     out  1      load instruct into the instruction register
//   pc_we     out  1      advance PC by 4
//   alu_op    out  4      ALU control code
//   alu_src   out  1      ALU B select: 0 = Data2, 1 = sign-extended imm
//   reg_we    out  1      register file write enable
//   wb_sel    out  1      writeback select: 0 = ALUout, 1 = read_data
//   mem_read  out  1      data memory read enable
//   mem_write out  1      data memory write enable
//   dmem_req  out  1      data memory access request
//   state     out  3      current FSM state
//   trap      out  1      sticky illegal-instruction / timeout flag
//   instret   out  CNT_W  retired-instruction count (wraps)
//
// state  | meaning
// -------+---------------------------------------------------------------
// FETCH  | load IR, latch opcode/funct3/funct7[5]
// DECODE | classify the latched opcode, trap on anything unsupported
// EXEC   | drive ALU controls
// MEM    | data access for LW/SW, bounded wait for dmem_ack
// WB     | register writeback, PC advance, retire
// TRAP   | everything idle until rst

module riscv_mc_ctrl #(
    parameter int MEM_TIMEOUT = 15,
    parameter int CNT_W       = 32
) (
    input  logic             clock,
    input  logic             rst,
    input  logic [31:0]      instruct,
    input  logic             dmem_ack,
    output logic             ir_we,
    output logic             pc_we,
    output logic [3:0]       alu_op,
    output logic             alu_src,
    output logic             reg_we,
    output logic             wb_sel,
    output logic             mem_read,
    output logic             mem_write,
    output logic             dmem_req,
    output logic [2:0]       state,
    output logic             trap,
    output logic [CNT_W-1:0] instret
);

    localparam int WAIT_W = $clog2(MEM_TIMEOUT + 1);

    localparam logic [6:0] OP_R  = 7'b0110011;
    localparam logic [6:0] OP_I  = 7'b0010011;
    localparam logic [6:0] OP_LW = 7'b0000011;
    localparam logic [6:0] OP_SW = 7'b0100011;

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4,
        S_TRAP   = 3'd5
    } state_t;

    state_t             state_q, state_d;
    logic [6:0]         opcode_q;
    logic [2:0]         funct3_q;
    logic               funct7b5_q;
    logic               trap_q;
    logic               sw_done_q;
    logic [WAIT_W-1:0]  wait_q;
    logic [CNT_W-1:0]   instret_q;

    logic               is_r, is_i, is_lw, is_sw, is_legal;
    logic               wait_last;
    logic               retire;
    logic [3:0]         alu_op_dec;

    // Instruction bits this controller never looks at.
    logic unused_instr_bits;
    assign unused_instr_bits = ^{instruct[31], instruct[29:15], instruct[11:7]};

    assign is_r     = (opcode_q == OP_R);
    assign is_i     = (opcode_q == OP_I);
    assign is_lw    = (opcode_q == OP_LW);
    assign is_sw    = (opcode_q == OP_SW);
    assign is_legal = is_r | is_i | is_lw | is_sw;

    assign wait_last = (wait_q == WAIT_W'(MEM_TIMEOUT - 1));

    // A store retires on its ack cycle; everything else retires in WB.
    assign retire = (state_q == S_WB) ||
                    ((state_q == S_MEM) && is_sw && dmem_ack);

    // I-type funct3=101 is SRLI/SRAI, where funct7[5] picks arithmetic shift.
    always_comb begin
        alu_op_dec = 4'b0000;
        if (is_r)
            alu_op_dec = {funct7b5_q, funct3_q};
        else if (is_i)
            alu_op_dec = (funct3_q == 3'b101) ? {funct7b5_q, 3'b101}
                                              : {1'b0, funct3_q};
    end

    always_ff @(posedge clock) begin
        if (rst) begin
            state_q    <= S_FETCH;
            opcode_q   <= '0;
            funct3_q   <= '0;
            funct7b5_q <= 1'b0;
            trap_q     <= 1'b0;
            sw_done_q  <= 1'b0;
            wait_q     <= '0;
            instret_q  <= '0;
        end else begin
            state_q <= state_d;
            if (state_q == S_FETCH) begin
                opcode_q   <= instruct[6:0];
                funct3_q   <= instruct[14:12];
                funct7b5_q <= instruct[30];
            end
            if (state_d == S_TRAP)
                trap_q <= 1'b1;
            if (state_q != S_MEM)
                wait_q <= '0;
            else if (!dmem_ack)
                wait_q <= wait_q + WAIT_W'(1);
            // The store's PC advance is issued from this flop in the cycle
            // after the ack, so no output follows dmem_ack combinationally.
            sw_done_q <= (state_q == S_MEM) && is_sw && dmem_ack;
            if (retire)
                instret_q <= instret_q + CNT_W'(1);
        end
    end

    always_comb begin
        state_d   = state_q;
        ir_we     = 1'b0;
        pc_we     = 1'b0;
        alu_op    = 4'b0000;
        alu_src   = 1'b0;
        reg_we    = 1'b0;
        wb_sel    = 1'b0;
        mem_read  = 1'b0;
        mem_write = 1'b0;
        dmem_req  = 1'b0;
        state     = 3'd0;
        trap      = 1'b0;

        case (state_q)
            S_FETCH:  state_d = S_DECODE;
            S_DECODE: state_d = is_legal ? S_EXEC : S_TRAP;
            S_EXEC:   state_d = (is_lw || is_sw) ? S_MEM : S_WB;
            S_MEM: begin
                if (dmem_ack)
                    state_d = is_lw ? S_WB : S_FETCH;
                else if (wait_last)
                    state_d = S_TRAP;
            end
            S_WB:     state_d = S_FETCH;
            S_TRAP:   state_d = S_TRAP;
            default:  state_d = S_FETCH;
        endcase

        // Outputs are forced idle while rst is high, whatever the state.
        if (!rst) begin
            state = state_q;
            trap  = trap_q;
            ir_we = (state_q == S_FETCH);
            pc_we = (state_q == S_WB) || sw_done_q;
            if (state_q == S_EXEC || state_q == S_MEM || state_q == S_WB) begin
                alu_op  = alu_op_dec;
                alu_src = ~is_r;
            end
            dmem_req  = (state_q == S_MEM);
            mem_read  = (state_q == S_MEM) && is_lw;
            mem_write = (state_q == S_MEM) && is_sw;
            reg_we    = (state_q == S_WB);
            wb_sel    = (state_q == S_WB) && is_lw;
        end
    end

    assign instret = instret_q;

endmodule

// File: tb/tb_riscv_mc_ctrl.sv
module tb_riscv_mc_ctrl;

    localparam int CW      = 4;
    localparam int TIMEOUT = 15;

    logic          clock = 1'b0;
    logic          rst = 1'b1;
    logic [31:0]   instruct = 32'h0;
    logic          dmem_ack = 1'b0;
    logic          ir_we, pc_we, alu_src, reg_we, wb_sel;
    logic          mem_read, mem_write, dmem_req, trap;
    logic [3:0]    alu_op;
    logic [2:0]    state;
    logic [CW-1:0] instret;

    riscv_mc_ctrl #(.MEM_TIMEOUT(TIMEOUT), .CNT_W(CW)) dut (
        .clock     (clock),
        .rst       (rst),
        .instruct  (instruct),
        .dmem_ack  (dmem_ack),
        .ir_we     (ir_we),
        .pc_we     (pc_we),
        .alu_op    (alu_op),
        .alu_src   (alu_src),
        .reg_we    (reg_we),
        .wb_sel    (wb_sel),
        .mem_read  (mem_read),
        .mem_write (mem_write),
        .dmem_req  (dmem_req),
        .state     (state),
        .trap      (trap),
        .instret   (instret)
    );

    always #5 clock = ~clock;

    logic [15:0] obs;
    assign obs = {state, ir_we, pc_we, alu_op, alu_src, reg_we, wb_sel,
                  mem_read, mem_write, dmem_req, trap};

    int n_vec = 0;
    int n_err = 0;
    int cyc = 0;
    int exp_instret = 0;
    logic pend_pc = 1'b0;

    function automatic logic [15:0] mk(input logic [2:0] st, input logic ir,
                                       input logic pc, input logic [3:0] aop,
                                       input logic asrc, input logic rwe,
                                       input logic wsel, input logic mr,
                                       input logic mw, input logic dreq,
                                       input logic tr);
        return {st, ir, pc, aop, asrc, rwe, wsel, mr, mw, dreq, tr};
    endfunction

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s cycle %0d: got %h expected %h", tag, cyc, got, exp);
        end
    endtask

    // One clock cycle: drive ack, check outputs mid-cycle, advance.
    task automatic step(input string tag, input logic [15:0] e, input logic ack);
        dmem_ack = ack;
        @(negedge clock);
        chk(tag, 32'(obs), 32'(e));
        chk("instret", 32'(instret), 32'(exp_instret % (1 << CW)));
        @(posedge clock);
        #1;
        cyc++;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        dmem_ack = 1'($urandom_range(0, 1));
        @(posedge clock);
        #1;
        exp_instret = 0;
        pend_pc = 1'b0;
        step("reset", 16'h0, 1'b1);
        rst = 1'b0;
    endtask

    task automatic trap_run();
        for (int t = 0; t < 4; t++)
            step("trap", mk(3'd5, 0, 0, 4'd0, 0, 0, 0, 0, 0, 0, 1),
                 (t == 0) ? 1'b1 : 1'($urandom_range(0, 1)));
        do_reset();
    endtask

    // ack_cyc: MEM cycle (1-based) carrying dmem_ack, 0 = never.
    // rst_cyc: MEM cycle in which rst is raised together with ack, 0 = never.
    task automatic run_instr(input logic [31:0] ins, input int ack_cyc,
                             input int rst_cyc);
        logic [6:0] op;
        logic [2:0] f3;
        logic       f7;
        logic       r, i, lw, sw, acked;
        logic [3:0] aop;
        logic       asrc;
        op = ins[6:0];
        f3 = ins[14:12];
        f7 = ins[30];
        r  = (op == 7'h33);
        i  = (op == 7'h13);
        lw = (op == 7'h03);
        sw = (op == 7'h23);
        aop = 4'd0;
        if (r)      aop = {f7, f3};
        else if (i) aop = (f3 == 3'd5) ? {f7, 3'd5} : {1'b0, f3};
        asrc = i | lw | sw;
        acked = 1'b0;

        instruct = ins;
        step("fetch", mk(3'd0, 1, pend_pc, 4'd0, 0, 0, 0, 0, 0, 0, 0),
             1'($urandom_range(0, 1)));
        pend_pc = 1'b0;
        instruct = $urandom;
        step("decode", mk(3'd1, 0, 0, 4'd0, 0, 0, 0, 0, 0, 0, 0),
             1'($urandom_range(0, 1)));
        if (!(r | i | lw | sw)) begin
            trap_run();
            return;
        end
        step("exec", mk(3'd2, 0, 0, aop, asrc, 0, 0, 0, 0, 0, 0),
             1'($urandom_range(0, 1)));
        if (lw | sw) begin
            for (int j = 1; j <= TIMEOUT; j++) begin
                if (j == rst_cyc) begin
                    rst = 1'b1;
                    step("rst_mem", 16'h0, 1'b1);
                    rst = 1'b0;
                    exp_instret = 0;
                    pend_pc = 1'b0;
                    return;
                end
                step("mem", mk(3'd3, 0, 0, aop, asrc, 0, 0, lw, sw, 1, 0),
                     (j == ack_cyc));
                if (j == ack_cyc) begin
                    acked = 1'b1;
                    break;
                end
            end
            if (!acked) begin
                trap_run();
                return;
            end
            if (sw) begin
                exp_instret++;
                pend_pc = 1'b1;
                return;
            end
        end
        step("wb", mk(3'd4, 0, 1, aop, asrc, 1, lw, 0, 0, 0, 0),
             1'($urandom_range(0, 1)));
        exp_instret++;
    endtask

    function automatic logic [31:0] rand_instr();
        logic [31:0] w;
        logic [6:0]  bad [6];
        bad = '{7'h6F, 7'h67, 7'h37, 7'h17, 7'h63, 7'h73};
        w = $urandom;
        case ($urandom_range(0, 9))
            0, 1, 2: w[6:0] = 7'h33;
            3, 4:    w[6:0] = 7'h13;
            5, 6:    w[6:0] = 7'h03;
            7, 8:    w[6:0] = 7'h23;
            default: w[6:0] = bad[$urandom_range(0, 5)];
        endcase
        return w;
    endfunction

    initial begin
        do_reset();
        // add x3,x1,x2
        run_instr(32'h002081B3, 0, 0);
        // srai
        run_instr(32'h4020D193, 0, 0);
        // lw with ack on the third MEM cycle
        run_instr(32'h0000A183, 3, 0);
        // sw with immediate ack, then one more R-type to see the PC pulse
        run_instr(32'h0030A023, 1, 0);
        run_instr(32'h40208233, 0, 0);
        // sw never acked -> timeout trap
        run_instr(32'h0030A023, 0, 0);
        // jal -> illegal trap, then lw interrupted by reset mid-MEM
        run_instr(32'h0000006F, 0, 0);
        run_instr(32'h0000A183, 5, 2);
        run_instr(32'h002081B3, 0, 0);

        for (int n = 0; n < 200; n++) begin
            int ack_c;
            int rst_c;
            ack_c = ($urandom_range(0, 19) == 0) ? 0 : $urandom_range(1, 5);
            rst_c = ($urandom_range(0, 24) == 0) ? $urandom_range(1, 3) : 0;
            run_instr(rand_instr(), ack_c, rst_c);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/riscv_mc_ctrl.md
RISCV_MC_CTRL -- requirements
Module: riscv_mc_ctrl

Interface
REQ-001 The block SHALL have parameter MEM_TIMEOUT, default 15: the maximum number of MEM-state cycles spent waiting for dmem_ack before trapping.
REQ-002 The block SHALL have parameter CNT_W, default 32: the width of the retired-instruction counter.
REQ-003 The block SHALL use one clock; reset is synchronous and active-high.
REQ-004 The block SHALL have these ports, one per line: name, direction, width, meaning.
  - clock  in  1  sole clock; all state changes on the rising edge.
  - rst  in  1  synchronous, active-high reset.
  - instruct  in  32  instruction word from instruction memory; combinational, valid for the current PC.
  - dmem_ack  in  1  data memory has completed the current access.
  - ir_we  out  1  latch instruct into the instruction register.
  - pc_we  out  1  advance PC by 4.
  - alu_op  out  4  ALU control code.
  - alu_src  out  1  ALU B operand select: 0 = Data2, 1 = sign-extended immediate.
  - reg_we  out  1  register file write enable.
  - wb_sel  out  1  writeback select: 0 = ALUout, 1 = memory read_data.
  - mem_read  out  1  data memory read enable.
  - mem_write  out  1  data memory write enable.
  - dmem_req  out  1  data memory access request.
  - state  out  3  current FSM state.
  - trap  out  1  sticky illegal-instruction or timeout flag.
  - instret  out  CNT_W  count of retired instructions.

Function
REQ-005 The FSM SHALL have these states and encodings: FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4, TRAP=5.
REQ-006 All outputs SHALL be registered or decoded from state plus the latched opcode/funct fields only; no output SHALL combinationally depend on dmem_ack.
REQ-007 FETCH: ir_we=1 for exactly one cycle; the opcode, funct3 and funct7[5] fields SHALL be latched from instruct; the next state is DECODE.
REQ-008 DECODE: outputs idle.
  - Latched opcode 0110011 (R), 0010011 (I), 0000011 (LW) or 0100011 (SW): next state is EXEC.
  - Any other opcode: next state is TRAP and trap is set.
REQ-009 EXEC: alu_op and alu_src SHALL be driven as follows.
  - R-type: alu_op={funct7[5],funct3}, alu_src=0.
  - I-type: alu_op={1'b0,funct3}, except funct3=101, where alu_op={funct7[5],3'b101}; alu_src=1.
  - LW/SW: alu_op=0000, alu_src=1.
  - Next state: MEM for LW/SW, WB for R/I.
REQ-010 alu_op and alu_src SHALL hold their EXEC values through the following MEM and WB states of the same instruction.
REQ-011 MEM: dmem_req=1 on every cycle in MEM, with mem_read=1 for LW or mem_write=1 for SW.
REQ-012 On a cycle in MEM with dmem_ack=1:
  - LW: next state is WB.
  - SW: pc_we=1, instret increments, and the next state is FETCH.
REQ-013 A dmem_ack arriving on the first MEM cycle SHALL be accepted.
REQ-014 The wait counter SHALL clear on MEM entry and increment on each MEM cycle without dmem_ack; on reaching MEM_TIMEOUT cycles without ack, the next state SHALL be TRAP with trap set.
REQ-015 dmem_ack received in any state other than MEM SHALL be ignored.
REQ-016 WB: reg_we=1 and pc_we=1 for one cycle; wb_sel=1 for LW and 0 otherwise; instret increments; the next state is FETCH.
REQ-017 TRAP: all enables SHALL be 0, the FSM SHALL remain in TRAP, and trap SHALL stay 1 until rst.
REQ-018 instret SHALL wrap modulo 2^CNT_W.
REQ-019 Instruction latency SHALL be 4 cycles for R/I, 5+k cycles for LW and 4+k cycles for SW, where k is the number of MEM cycles before ack.

Reset
REQ-020 When rst=1 at a clock edge, the next state SHALL be FETCH, and trap, instret, the wait counter and the latched fields SHALL be 0.
REQ-021 While in reset all outputs SHALL be 0: ir_we, pc_we, reg_we, wb_sel, mem_read, mem_write, dmem_req, alu_op=0000, alu_src=0 and state=0.
REQ-022 rst SHALL take priority over every transition, including a reset asserted in MEM with dmem_ack=1: no pc_we, no reg_we and no instret increment in that cycle.
REQ-023 ir_we SHALL be asserted in the first cycle after rst is released.

Verification
REQ-024 The bench SHALL cover these directed scenarios (stimulus -> required response):
  - instruct=0x002081B3 (add x3,x1,x2) -> states 0,1,2,4; alu_op=0000, alu_src=0; reg_we and pc_we high in cycle 4; instret=1.
  - instruct=0x4020D193 (srai) -> alu_op=1101, alu_src=1.
  - LW with dmem_ack on the 3rd MEM cycle -> mem_read=1 for 3 cycles, then WB with wb_sel=1; total latency 7 cycles.
  - SW with immediate ack -> mem_write=1 for 1 cycle, pc_we with the return to FETCH, reg_we never asserted.
  - SW with no ack -> after 15 MEM cycles state=5 and trap=1; a stray ack afterwards has no effect; rst returns state to 0.
  - instruct=0x0000006F (JAL, unsupported) -> TRAP after DECODE; rst asserted mid-MEM of a following LW clears dmem_req on the next cycle.
